// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the sequential ALU core.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH iterations,
// done pulses for one cycle once the product register holds the final value.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNTW-1:0]    r_cnt;
  logic               r_run;
  logic               r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_run) begin
      if (r_mplier[0]) begin
        r_prod <= r_prod + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNTW'(1);
      // Last multiplier bit consumed this cycle: stop and flag completion.
      if (r_cnt == CNTW'(WIDTH - 1)) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done    = r_done;
  assign product = r_prod;

endmodule

// File: rtl/seq_alu_core.sv
// Registered WIDTH-bit ALU with accumulator, iterative multiply and
// valid/ready handshakes on both the operand and the result side.
module seq_alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               use_acc,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [3:0]         flags,
  output logic               busy
);

  localparam int SHW = $clog2(WIDTH);

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_mul_start;
  logic                 w_mul_done;
  logic [2*WIDTH-1:0]   w_mul_prod;
  logic [WIDTH-1:0]     w_a_sel;

  logic [2:0]           r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_acc;
  logic [2*WIDTH-1:0]   r_result;
  logic [3:0]           r_flags;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH:0]       w_shl_ext;
  logic [SHW:0]         w_shamt;
  logic                 w_sh_in_range;
  logic [WIDTH-1:0]     w_lo;
  logic                 w_c;
  logic                 w_v;
  logic [3:0]           w_alu_flags;
  logic [3:0]           w_mul_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // HOLD can take a new operation in the same cycle its result is consumed.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = (op == OP_MUL) ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: w_state_next = ST_HOLD;
      ST_MUL: begin
        if (w_mul_done) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_in_ready   = 1'b1;
          w_state_next = in_valid ? ((op == OP_MUL) ? ST_MUL : ST_EXEC) : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_accept    = in_valid & w_in_ready;
  assign w_mul_start = w_accept & (op == OP_MUL);
  assign w_a_sel     = use_acc ? r_acc : a;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (w_a_sel),
    .b       (b),
    .done    (w_mul_done),
    .product (w_mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= op;
      r_a  <= w_a_sel;
      r_b  <= b;
    end
  end

  assign w_sum         = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff        = {1'b0, r_a} - {1'b0, r_b};
  assign w_sh_in_range = (r_b <= WIDTH'(WIDTH));
  assign w_shamt       = r_b[SHW:0];
  assign w_shl_ext     = {1'b0, r_a} << w_shamt;

  // Bit WIDTH of the widened left shift is the last bit pushed out of the operand.
  always_comb begin
    w_lo = '0;
    w_c  = 1'b0;
    w_v  = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_lo = w_sum[WIDTH-1:0];
        w_c  = w_sum[WIDTH];
        w_v  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_lo = w_diff[WIDTH-1:0];
        w_c  = w_diff[WIDTH];
        w_v  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_lo = r_a & r_b;
      OP_OR:  w_lo = r_a | r_b;
      OP_XOR: w_lo = r_a ^ r_b;
      OP_SHL: begin
        if (w_sh_in_range) begin
          w_lo = w_shl_ext[WIDTH-1:0];
          w_c  = w_shl_ext[WIDTH];
        end
      end
      OP_SHR: begin
        if (w_sh_in_range) begin
          w_lo = r_a >> w_shamt;
        end
      end
      default: w_lo = '0;
    endcase
  end

  always_comb begin
    w_alu_flags        = '0;
    w_alu_flags[FLG_Z] = (w_lo == '0);
    w_alu_flags[FLG_N] = w_lo[WIDTH-1];
    w_alu_flags[FLG_C] = w_c;
    w_alu_flags[FLG_V] = w_v;
  end

  always_comb begin
    w_mul_flags        = '0;
    w_mul_flags[FLG_Z] = (w_mul_prod == '0);
    w_mul_flags[FLG_N] = w_mul_prod[2*WIDTH-1];
    w_mul_flags[FLG_C] = (w_mul_prod[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (r_state == ST_EXEC) begin
      r_result <= {{WIDTH{1'b0}}, w_lo};
      r_flags  <= w_alu_flags;
    end else if ((r_state == ST_MUL) && w_mul_done) begin
      r_result <= w_mul_prod;
      r_flags  <= w_mul_flags;
    end
  end

  // A clear request overrides the accumulate from a completing handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if ((r_state == ST_HOLD) && out_ready) begin
      r_acc <= r_result[WIDTH-1:0];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == ST_HOLD);
  assign busy      = (r_state == ST_MUL) && !w_mul_done;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core (WIDTH=8): vector table plus hand-written
// sequences for stall, accumulator, reset-abort and clear corner cases.
module tb_seq_alu_core;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        use_acc;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        useAcc;
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  seq_alu_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .use_acc   (use_acc),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Present one operation, wait (bounded) for its result, and check it.
  task automatic applyStimulus(input logic [2:0] vOp, input logic [7:0] vA, input logic [7:0] vB,
                               input logic vUseAcc, input logic [15:0] expRes, input logic [3:0] expFlg,
                               input int expLat, input string name);
    int lat;
    int busyCnt;
    @(negedge clk);
    op = vOp; a = vA; b = vB; use_acc = vUseAcc; in_valid = 1'b1;
    checkOutput({name, " in_ready"}, 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput({name, " in_ready after accept"}, 16'(in_ready), 16'd0);
    lat = 0;
    busyCnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busyCnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, " latency"}, 16'(lat), 16'(expLat));
    checkOutput({name, " busy cycles"}, 16'(busyCnt), (vOp == OP_MUL) ? 16'd8 : 16'd0);
    checkOutput({name, " result"}, result, expRes);
    checkOutput({name, " flags"}, 16'(flags), 16'(expFlg));
  endtask

  initial begin
    int lat;
    int seen;

    // flags are {V,C,N,Z}
    vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 1'b0, 16'h0000, 4'b0101, 1};
    vecs[1]  = '{OP_SUB, 8'h80, 8'h01, 1'b0, 16'h007F, 4'b1000, 1};
    vecs[2]  = '{OP_SUB, 8'h00, 8'h01, 1'b0, 16'h00FF, 4'b0110, 1};
    vecs[3]  = '{OP_AND, 8'hF0, 8'h3C, 1'b0, 16'h0030, 4'b0000, 1};
    vecs[4]  = '{OP_OR,  8'h0F, 8'h80, 1'b0, 16'h008F, 4'b0010, 1};
    vecs[5]  = '{OP_XOR, 8'hAA, 8'hAA, 1'b0, 16'h0000, 4'b0001, 1};
    vecs[6]  = '{OP_SHL, 8'h81, 8'h01, 1'b0, 16'h0002, 4'b0100, 1};
    vecs[7]  = '{OP_SHR, 8'h81, 8'h09, 1'b0, 16'h0000, 4'b0001, 1};
    vecs[8]  = '{OP_SHL, 8'h81, 8'h08, 1'b0, 16'h0000, 4'b0101, 1};
    vecs[9]  = '{OP_SHL, 8'h81, 8'h09, 1'b0, 16'h0000, 4'b0001, 1};
    vecs[10] = '{OP_SHR, 8'h80, 8'h07, 1'b0, 16'h0001, 4'b0000, 1};
    vecs[11] = '{OP_MUL, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 4'b0110, 9};
    vecs[12] = '{OP_MUL, 8'h00, 8'h37, 1'b0, 16'h0000, 4'b0001, 9};
    vecs[13] = '{OP_MUL, 8'h0D, 8'h0B, 1'b0, 16'h008F, 4'b0000, 9};
    vecs[14] = '{OP_ADD, 8'h7F, 8'h01, 1'b0, 16'h0080, 4'b1010, 1};
    vecs[15] = '{OP_SHL, 8'h40, 8'h01, 1'b0, 16'h0080, 4'b0010, 1};
    vecs[16] = '{OP_SUB, 8'h05, 8'h03, 1'b0, 16'h0002, 4'b0000, 1};
    vecs[17] = '{OP_MUL, 8'h10, 8'h10, 1'b0, 16'h0100, 4'b0100, 9};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
    op = OP_ADD; a = '0; b = '0; use_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 16'(out_valid), 16'd0);
    checkOutput("reset in_ready", 16'(in_ready), 16'd1);
    checkOutput("reset busy", 16'(busy), 16'd0);
    checkOutput("reset result", result, 16'h0000);
    checkOutput("reset flags", 16'(flags), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].useAcc, vecs[i].res,
                    vecs[i].flg, vecs[i].lat, $sformatf("vec%0d", i));
    end
    @(posedge clk);
    #1;

    // Stall the consumer; a request presented meanwhile must be ignored.
    out_ready = 1'b0;
    @(negedge clk);
    op = OP_ADD; a = 8'h03; b = 8'h04; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("hold latency", 16'(lat), 16'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid = 1'b1; op = OP_SUB; a = 8'h55; b = 8'h11;
      end
      @(posedge clk);
      #1;
      checkOutput("hold result", result, 16'h0007);
      checkOutput("hold out_valid", 16'(out_valid), 16'd1);
      checkOutput("hold in_ready", 16'(in_ready), 16'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    checkOutput("release out_valid", 16'(out_valid), 16'd0);

    applyStimulus(OP_ADD, 8'h00, 8'h01, 1'b1, 16'h0008, 4'b0000, 1, "acc add");
    // Accepted on the same edge that consumes 0x08, so ACC is still 0x07.
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b1, 16'h0007, 4'b0000, 1, "acc pre-update");

    // Abort a multiply with an asynchronous reset.
    @(negedge clk);
    op = OP_MUL; a = 8'hFF; b = 8'hFF; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("mul busy before reset", 16'(busy), 16'd1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("abort out_valid count", 16'(seen), 16'd0);
    checkOutput("abort in_ready", 16'(in_ready), 16'd1);
    checkOutput("abort busy", 16'(busy), 16'd0);
    checkOutput("abort result", result, 16'h0000);
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b1, 16'h0000, 4'b0001, 1, "acc after reset");

    // acc_clr coinciding with a completing handshake.
    applyStimulus(OP_ADD, 8'h03, 8'h04, 1'b0, 16'h0007, 4'b0000, 1, "pre clr");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 8'h05, 8'h06, 1'b0, 16'h000B, 4'b0000, 1, "clr op");
    @(negedge clk);
    acc_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b1, 16'h0000, 4'b0001, 1, "acc after clr");
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
